// File: rtl/output_buffer_drain.sv
// ---------------------------------------------------------------------------
// output_buffer_drain
//   Result store fed by the Accumulator's output-buffer write port. It holds
//   DEPTH result words and keeps a per-entry "unread" flag. A host command
//   streams a contiguous (modulo DEPTH) address range out over valid/ready.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   wr_en/addr/data   write port from the Accumulator (accepted in any state)
//   rd_start          start a drain (only sampled while idle)
//   rd_base, rd_len   first address and word count (0..DEPTH) of the drain
//   out_valid/ready   output handshake
//   out_data/addr     drained word and its buffer address
//   busy              drain engine not idle
//   done              one-cycle pulse once the drain has completed
//   entry_valid       bit i = entry i written and not yet drained
//   ovw_err           sticky: an unread entry was overwritten
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready
// are both 1. While out_valid is 1 and the beat has not transferred,
// out_data and out_addr stay constant. out_valid never drops without a
// transfer, except on reset.
// ---------------------------------------------------------------------------
module output_buffer_drain #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DEPTH-1:0]  entry_valid,
  output logic              ovw_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;

  logic              hs;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              clr_en;
  logic              last_beat;
  logic [DEPTH-1:0]  entry_valid_nxt;

  assign hs        = out_valid & out_ready;
  assign last_beat = (rem == REM_ONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rd_start) state_nxt = (rd_len == '0) ? S_FIN : S_FETCH;
      S_FETCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (hs && last_beat) state_nxt = S_FIN;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state != S_IDLE);
    load_en   = 1'b0;
    load_addr = ptr;
    clr_en    = 1'b0;
    case (state)
      S_FETCH: load_en = 1'b1;
      S_PRESENT: begin
        if (hs) begin
          clr_en = 1'b1;
          if (!last_beat) begin
            // Load the next word straight away to sustain 1 beat/cycle.
            load_en   = 1'b1;
            load_addr = ADDR_W'(ptr + 1'b1);
          end
        end
      end
      default: ;
    endcase
  end

  // A write landing on the word being loaded this edge is forwarded, so the
  // consumer never sees the stale value.
  assign load_data = (wr_en && (wr_addr == load_addr)) ? wr_data : mem[load_addr];

  // Drain-clear first, then write-set: a same-edge write to the entry being
  // drained leaves it marked unread.
  always_comb begin
    entry_valid_nxt = entry_valid;
    if (clr_en) entry_valid_nxt[ptr] = 1'b0;
    if (wr_en)  entry_valid_nxt[wr_addr] = 1'b1;
  end

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_addr] <= wr_data;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr         <= '0;
      rem         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      done        <= 1'b0;
      entry_valid <= '0;
      ovw_err     <= 1'b0;
    end else begin
      done        <= (state == S_FIN);
      entry_valid <= entry_valid_nxt;
      if (state == S_IDLE && rd_start) begin
        ptr <= rd_base;
        rem <= rd_len;
      end
      if (load_en) begin
        out_data  <= load_data;
        out_addr  <= load_addr;
        out_valid <= 1'b1;
      end
      if (state == S_PRESENT && hs) begin
        if (last_beat) begin
          out_valid <= 1'b0;
        end else begin
          ptr <= ADDR_W'(ptr + 1'b1);
          rem <= rem - 1'b1;
        end
      end
      // An entry drained on this same edge does not count as overwritten.
      if (wr_en && entry_valid[wr_addr] && !(clr_en && (ptr == wr_addr)))
        ovw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_buffer_drain.sv
// ---------------------------------------------------------------------------
// tb_output_buffer_drain
//   Directed bench for output_buffer_drain: a write-vector table plus
//   hand-written drain sequences with an expected-beat queue.
// ---------------------------------------------------------------------------
module tb_output_buffer_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_start;
  logic [3:0]  rd_base;
  logic [4:0]  rd_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_addr;
  logic        busy;
  logic        done;
  logic [15:0] entry_valid;
  logic        ovw_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] exp_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_ev;
    logic        exp_ovw;
  } wr_vec_t;

  wr_vec_t wv[9];

  output_buffer_drain #(.DATA_W(32), .ADDR_W(4), .DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_start    (rd_start),
    .rd_base     (rd_base),
    .rd_len      (rd_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .entry_valid (entry_valid),
    .ovw_err     (ovw_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic push_beat(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Start a drain and consume it. bp toggles out_ready (0 first); hold keeps
  // rd_start asserted with a different range for the whole drain.
  task automatic run_drain(input logic [3:0] base, input logic [4:0] len,
                           input bit bp, input bit hold);
    int dones = 0;
    int first = -1;
    int last  = -1;
    bit held  = 1'b0;
    logic [31:0] hd;
    logic [3:0]  ha;
    logic [35:0] e;
    rd_start = 1'b1; rd_base = base; rd_len = len;
    step();
    if (hold) begin
      rd_base = 4'h0; rd_len = 5'd1;
    end else begin
      rd_start = 1'b0;
    end
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (done) begin
        dones++;
        rd_start = 1'b0;
        break;
      end
      out_ready = bp ? (cyc % 2 == 1) : 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got addr 0x%0h data 0x%0h expected no beat", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", out_addr, e[35:32]);
          check("beat_data", out_data, e[31:0]);
        end
        if (first < 0) first = cyc;
        last = cyc;
      end
      held = out_valid && !out_ready;
      hd = out_data; ha = out_addr;
      step();
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_addr", out_addr, ha);
      end
    end
    rd_start = 1'b0;
    check("drain_done_seen", dones, 1);
    check("beats_missing", exp_q.size(), 0);
    if (!bp && len != 0) check("throughput", last - first, len - 1);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
    step();
    check("done_width", done, 0);
    check("idle_after", busy, 0);
    out_ready = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    // Write-vector table: address, data, expected entry_valid and ovw_err
    wv[0] = '{4'h0, 32'd10, 16'h0001, 1'b0};
    wv[1] = '{4'h1, 32'd20, 16'h0003, 1'b0};
    wv[2] = '{4'h2, 32'd30, 16'h0007, 1'b0};
    wv[3] = '{4'h3, 32'd40, 16'h000F, 1'b0};
    wv[4] = '{4'hE, 32'd5,  16'h400F, 1'b0};
    wv[5] = '{4'hF, 32'd15, 16'hC00F, 1'b0};
    // After reset; entry 12 still unread from the same-edge test
    wv[6] = '{4'hA, 32'hA1, 16'h1400, 1'b0};
    wv[7] = '{4'hA, 32'hA2, 16'h1400, 1'b1};
    wv[8] = '{4'hB, 32'hB1, 16'h1C00, 1'b1};

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b1;
    step(); step();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ev", entry_valid, 0);
    check("rst_ovw", ovw_err, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", out_addr, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      do_write(wv[i].addr, wv[i].data);
      check("wr_ev", entry_valid, wv[i].exp_ev);
      check("wr_ovw", ovw_err, wv[i].exp_ovw);
    end

    // Basic drain 0..3
    push_beat(4'h0, 32'd10); push_beat(4'h1, 32'd20);
    push_beat(4'h2, 32'd30); push_beat(4'h3, 32'd40);
    run_drain(4'h0, 5'd4, 1'b0, 1'b0);
    check("basic_ev", entry_valid, 16'hC000);

    // Wrap 14,15,0
    do_write(4'h0, 32'd25);
    check("wrap_pre_ev", entry_valid, 16'hC001);
    push_beat(4'hE, 32'd5); push_beat(4'hF, 32'd15); push_beat(4'h0, 32'd25);
    run_drain(4'hE, 5'd3, 1'b0, 1'b0);
    check("wrap_ev", entry_valid, 16'h0000);

    // Backpressure
    do_write(4'h6, 32'h66); do_write(4'h7, 32'h77); do_write(4'h8, 32'h88);
    check("bp_pre_ev", entry_valid, 16'h01C0);
    push_beat(4'h6, 32'h66); push_beat(4'h7, 32'h77); push_beat(4'h8, 32'h88);
    run_drain(4'h6, 5'd3, 1'b1, 1'b0);
    check("bp_ev", entry_valid, 16'h0000);

    // Zero-length drain: done only, no beats
    run_drain(4'h5, 5'd0, 1'b0, 1'b0);

    // rd_start held during a drain is ignored
    do_write(4'h9, 32'h99); do_write(4'hA, 32'hAA);
    push_beat(4'h9, 32'h99); push_beat(4'hA, 32'hAA);
    run_drain(4'h9, 5'd2, 1'b1, 1'b1);
    check("busy_ignore_ev", entry_valid, 16'h0000);

    // Forwarding on the PRESENT-path load of entry 5
    do_write(4'h4, 32'h44);
    rd_start = 1'b1; rd_base = 4'h4; rd_len = 5'd2; out_ready = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    check("fwd_valid", out_valid, 1);
    check("fwd_addr0", out_addr, 4'h4);
    check("fwd_data0", out_data, 32'h44);
    wr_en = 1'b1; wr_addr = 4'h5; wr_data = 32'h55;
    step();
    wr_en = 1'b0;
    check("fwd_addr1", out_addr, 4'h5);
    check("fwd_data1", out_data, 32'h55);
    check("fwd_ev_mid", entry_valid, 16'h0020);
    step();
    check("fwd_valid_end", out_valid, 0);
    check("fwd_ev_end", entry_valid, 16'h0000);
    check("fwd_ovw", ovw_err, 0);
    step();
    check("fwd_done", done, 1);
    step();

    // Reset mid-stream with a beat stalled on the output
    do_write(4'h1, 32'h11); do_write(4'h2, 32'h22);
    out_ready = 1'b0;
    rd_start = 1'b1; rd_base = 4'h1; rd_len = 5'd2;
    step();
    rd_start = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) step();
    check("rst_mid_pre_valid", out_valid, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ev", entry_valid, 0);
    check("rst_mid_done", done, 0);
    out_ready = 1'b1;
    step();
    check("rst_mid_done2", done, 0);
    check("rst_mid_busy2", busy, 0);

    // Same-edge write and drain-clear of entry 12
    do_write(4'hC, 32'd1);
    rd_start = 1'b1; rd_base = 4'hC; rd_len = 5'd1;
    step();
    rd_start = 1'b0;
    step();
    check("same_data", out_data, 32'd1);
    wr_en = 1'b1; wr_addr = 4'hC; wr_data = 32'd2;
    step();
    wr_en = 1'b0;
    check("same_ev", entry_valid, 16'h1000);
    check("same_ovw", ovw_err, 0);
    step();
    check("same_done", done, 1);
    step();

    // Overwrite error: sticky once set
    for (int i = 6; i < 9; i++) begin
      do_write(wv[i].addr, wv[i].data);
      check("ovw_ev", entry_valid, wv[i].exp_ev);
      check("ovw_flag", ovw_err, wv[i].exp_ovw);
    end
    push_beat(4'hA, 32'hA2);
    run_drain(4'hA, 5'd1, 1'b0, 1'b0);
    check("ovw_sticky", ovw_err, 1);
    check("ovw_final_ev", entry_valid, 16'h1800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
